tx_req_demux: RTL and testbench
===============================

// Module: tx_req_demux
// PURPOSE
// Routes one transmit request stream to one of PORTS transmit engines, selected by the low dest bits.
// Merges the engines' dequeue/start/finish status streams back into one stream per type.
// Per-port credit counters bound outstanding requests, so the valid-only status buffers cannot overflow.
// Sits between the scheduler-side request source and a bank of parallel transmit engines.
// PARAMETERS
// PORTS             2   number of transmit engines (>=2); SEL_W = $clog2(PORTS)
// QUEUE_INDEX_WIDTH 4   queue index width
// REQ_TAG_WIDTH     8   request tag width; passed through unchanged, echoed by engines
// DEST_WIDTH        8   dest width (>= SEL_W); dest[SEL_W-1:0] selects the engine
// LEN_WIDTH         20  status length width
// MAX_OUTSTANDING   4   per-port credit limit and per-port, per-channel status FIFO depth (power of 2)
// PORTS
// clk                         in   1                clock
// rst                         in   1                synchronous, active-high reset
// s_axis_req_queue/tag/dest   in   QI/TAG/DEST      request in
// s_axis_req_valid/ready      in/out 1              request handshake
// m_axis_req_queue/tag/dest   out  PORTS*QI/TAG/DEST  per-engine request; fields shared across ports
// m_axis_req_valid/ready      out/in PORTS          per-engine handshake
// s_axis_status_dequeue_empty/error/tag/valid  in  PORTS*(1/1/TAG/1)  from engines
// s_axis_status_start_error/len/tag/valid      in  PORTS*(1/LEN/TAG/1)
// s_axis_status_finish_len/tag/valid           in  PORTS*(LEN/TAG/1)
// m_axis_status_dequeue_empty/error/tag/valid  out 1/1/TAG/1       merged; valid-only, no ready
// m_axis_status_start_error/len/tag/valid      out 1/LEN/TAG/1
// m_axis_status_finish_len/tag/valid           out LEN/TAG/1
// BEHAVIOUR
// - Reset: all m_*_valid=0; s_axis_req_ready=0 during rst. Credits=MAX_OUTSTANDING. FIFOs empty. RR pointers=0. Data outputs don't-care.
// - Request path: one holding register (hold_valid, hold_port).
//   - s_axis_req_ready = !hold_valid || m_axis_req_ready[hold_port]; further gated by credit[sel]>0 when sel<PORTS.
//   - On accept: latch fields and hold_port=sel.
//     - sel<PORTS: decrement credit[sel]. m_axis_req_valid = onehot(hold_port) & hold_valid.
//     - Latency 1 cycle; full throughput when the target is ready.
//   - sel>=PORTS (bad dest): accept without credit; no engine output.
//     - Next cycle, a local dequeue status (error=1, empty=0, tag=input tag) enters the dequeue merge as source PORTS.
//     - Further bad-dest requests stall while that 1-entry local slot is occupied.
// - Status merge: each channel (dequeue/start/finish) has PORTS FIFOs of depth MAX_OUTSTANDING.
//   - Push whenever the engine asserts valid; multiple ports may push in the same cycle.
//   - Per channel, a round-robin arbiter pops one non-empty source per cycle into the output register.
//     - Dequeue arbitration covers PORTS+1 sources.
//     - Pointer advances past the granted source.
//   - Latency: engine status at cycle N -> output valid at N+2 when uncontended. Sustains 1/cycle per channel.
//   - Channels are independent; their relative output order is not guaranteed across channels.
// - Credit return, per port, on pop from that port's FIFO:
//   - dequeue pop with empty|error: +1;
//   - finish pop: +1;
//   - start pop: none.
//   - The simultaneous issue decrement and return increment on one port net to 0.
//   - Credit never exceeds MAX_OUTSTANDING.
//   - Engines emit at most one dequeue (+ start + finish on success) per request, so FIFO overflow is impossible.
//   - A push to a full FIFO is a protocol violation; simulation $error.
// - Reset mid-operation: in-flight requests and buffered status are discarded; credits restored.
// TESTING
// 1. dest=1, tag=0x5A, queue=3, port1 ready -> m_axis_req_valid=2'b10 next cycle, tag=0x5A, queue=3; credit[1]=3.
// 2. Issue 4 reqs to port0, no status -> 5th stalls (ready=0). Finish for tag0 -> 5th issued within 3 cycles.
// 3. Ports 0 and 1 assert finish same cycle (tags 0x11, 0x22) -> outputs at N+2 (0x11) and N+3 (0x22); RR then favours port1 first.
// 4. PORTS=3, dest=3 tag=0x7 -> no engine valid; dequeue status error=1 empty=0 tag=0x7 at cycle+2.
// 5. Port0 dequeue empty=1 -> credit[0] returns; no start/finish expected; next request to port0 accepted.
// 6. rst asserted while hold_valid and FIFOs non-empty -> all valids 0 next cycle; credits=MAX_OUTSTANDING.

Source files
------------

// File: rtl/tx_req_demux.sv
// rtl/tx_req_demux.sv - transmit request demux to PORTS engines with credit-bounded status merge
// Status channels share one merge block: per-source FIFOs, round-robin pop, registered output.
module tx_req_demux_merge #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_valid,
  input  logic [N*W-1:0] i_data,
  output logic [N-1:0]   o_pop,
  output logic [W-1:0]   o_pop_data,
  output logic           o_valid,
  output logic [W-1:0]   o_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(N);

  logic [W-1:0]  r_mem [N][DEPTH];
  logic [PW-1:0] r_wr  [N];
  logic [PW-1:0] r_rd  [N];
  logic [CW-1:0] r_cnt [N];
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_nonempty;
  logic [IW-1:0] w_gidx;
  logic [IW-1:0] w_cand;

  always_comb begin
    w_nonempty = '0;
    for (int s = 0; s < N; s++) w_nonempty[s] = (r_cnt[s] != '0);
  end

  // Scan from the farthest offset down so the source nearest r_ptr wins.
  always_comb begin
    o_pop  = '0;
    w_gidx = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (w_nonempty[w_cand]) w_gidx = w_cand;
    end
    o_pop[w_gidx] = |w_nonempty;
    o_pop_data    = r_mem[w_gidx][r_rd[w_gidx]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N; s++) begin
        r_wr[s]  <= '0;
        r_rd[s]  <= '0;
        r_cnt[s] <= '0;
      end
      r_ptr   <= '0;
      o_valid <= 1'b0;
    end else begin
      for (int s = 0; s < N; s++) begin
        assert (!(i_valid[s] && r_cnt[s] == CW'(DEPTH) && !o_pop[s]))
          else $error("status fifo overflow on source %0d", s);
        if (i_valid[s]) begin
          r_mem[s][r_wr[s]] <= i_data[s*W +: W];
          r_wr[s]           <= r_wr[s] + 1'b1;
        end
        if (o_pop[s]) r_rd[s] <= r_rd[s] + 1'b1;
        r_cnt[s] <= r_cnt[s] + CW'(i_valid[s]) - CW'(o_pop[s]);
      end
      o_valid <= |o_pop;
      if (|o_pop) r_ptr <= (w_gidx == IW'(N - 1)) ? '0 : w_gidx + 1'b1;
    end
    o_data <= o_pop_data;
  end
endmodule

module tx_req_demux #(
  parameter int PORTS             = 2,
  parameter int QUEUE_INDEX_WIDTH = 4,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int DEST_WIDTH        = 8,
  parameter int LEN_WIDTH         = 20,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0]         s_axis_req_queue,
  input  logic [REQ_TAG_WIDTH-1:0]             s_axis_req_tag,
  input  logic [DEST_WIDTH-1:0]                s_axis_req_dest,
  input  logic                                 s_axis_req_valid,
  output logic                                 s_axis_req_ready,
  output logic [PORTS*QUEUE_INDEX_WIDTH-1:0]   m_axis_req_queue,
  output logic [PORTS*REQ_TAG_WIDTH-1:0]       m_axis_req_tag,
  output logic [PORTS*DEST_WIDTH-1:0]          m_axis_req_dest,
  output logic [PORTS-1:0]                     m_axis_req_valid,
  input  logic [PORTS-1:0]                     m_axis_req_ready,
  input  logic [PORTS-1:0]                     s_axis_status_dequeue_empty,
  input  logic [PORTS-1:0]                     s_axis_status_dequeue_error,
  input  logic [PORTS*REQ_TAG_WIDTH-1:0]       s_axis_status_dequeue_tag,
  input  logic [PORTS-1:0]                     s_axis_status_dequeue_valid,
  input  logic [PORTS-1:0]                     s_axis_status_start_error,
  input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_status_start_len,
  input  logic [PORTS*REQ_TAG_WIDTH-1:0]       s_axis_status_start_tag,
  input  logic [PORTS-1:0]                     s_axis_status_start_valid,
  input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_status_finish_len,
  input  logic [PORTS*REQ_TAG_WIDTH-1:0]       s_axis_status_finish_tag,
  input  logic [PORTS-1:0]                     s_axis_status_finish_valid,
  output logic                                 m_axis_status_dequeue_empty,
  output logic                                 m_axis_status_dequeue_error,
  output logic [REQ_TAG_WIDTH-1:0]             m_axis_status_dequeue_tag,
  output logic                                 m_axis_status_dequeue_valid,
  output logic                                 m_axis_status_start_error,
  output logic [LEN_WIDTH-1:0]                 m_axis_status_start_len,
  output logic [REQ_TAG_WIDTH-1:0]             m_axis_status_start_tag,
  output logic                                 m_axis_status_start_valid,
  output logic [LEN_WIDTH-1:0]                 m_axis_status_finish_len,
  output logic [REQ_TAG_WIDTH-1:0]             m_axis_status_finish_tag,
  output logic                                 m_axis_status_finish_valid
);
  localparam int SEL_W = $clog2(PORTS);
  localparam int CRW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW    = REQ_TAG_WIDTH;
  localparam int DQW   = TW + 2;
  localparam int STW   = TW + LEN_WIDTH + 1;
  localparam int FNW   = TW + LEN_WIDTH;

  logic                         r_hold_valid;
  logic [SEL_W-1:0]             r_hold_port;
  logic [QUEUE_INDEX_WIDTH-1:0] r_queue;
  logic [TW-1:0]                r_tag;
  logic [DEST_WIDTH-1:0]        r_dest;
  logic [CRW-1:0]               r_credit [PORTS];
  logic                         r_loc_busy;

  logic [SEL_W-1:0] w_sel;
  logic             w_sel_ok;
  logic             w_accept;
  logic             w_loc_push;
  logic [CRW:0]     w_cnext [PORTS];

  logic [PORTS:0]           w_dq_pop;
  logic [DQW-1:0]           w_dq_pop_data, w_dq_out;
  logic [(PORTS+1)*DQW-1:0] w_dq_in;
  logic [PORTS-1:0]         w_st_pop, w_fn_pop;
  logic [STW-1:0]           w_st_pop_data, w_st_out;
  logic [PORTS*STW-1:0]     w_st_in;
  logic [FNW-1:0]           w_fn_pop_data, w_fn_out;
  logic [PORTS*FNW-1:0]     w_fn_in;
  logic                     w_unused_pop;

  assign w_sel      = s_axis_req_dest[SEL_W-1:0];
  assign w_sel_ok   = int'(w_sel) < PORTS;
  assign s_axis_req_ready = !rst && (!r_hold_valid || m_axis_req_ready[r_hold_port]) &&
                            (w_sel_ok ? (r_credit[w_sel] != '0) : !r_loc_busy);
  assign w_accept   = s_axis_req_valid && s_axis_req_ready;
  assign w_loc_push = w_accept && !w_sel_ok;

  assign m_axis_req_valid = r_hold_valid ? (PORTS'(1) << r_hold_port) : '0;
  assign m_axis_req_queue = {PORTS{r_queue}};
  assign m_axis_req_tag   = {PORTS{r_tag}};
  assign m_axis_req_dest  = {PORTS{r_dest}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_loc_busy   <= 1'b0;
    end else begin
      if (w_accept) r_hold_valid <= w_sel_ok;
      else if (r_hold_valid && m_axis_req_ready[r_hold_port]) r_hold_valid <= 1'b0;
      // The local error slot is one deep, so push and pop never coincide.
      if (w_loc_push) r_loc_busy <= 1'b1;
      else if (w_dq_pop[PORTS]) r_loc_busy <= 1'b0;
    end
    if (w_accept) begin
      r_hold_port <= w_sel;
      r_queue     <= s_axis_req_queue;
      r_tag       <= s_axis_req_tag;
      r_dest      <= s_axis_req_dest;
    end
  end

  // Issue and return on one port in the same cycle cancel; the clamp keeps stray returns harmless.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_cnext[p] = {1'b0, r_credit[p]}
                 + (CRW+1)'(w_dq_pop[p] && (w_dq_pop_data[DQW-1] || w_dq_pop_data[DQW-2]))
                 + (CRW+1)'(w_fn_pop[p])
                 - (CRW+1)'(w_accept && w_sel_ok && (w_sel == SEL_W'(p)));
      if (w_cnext[p] > (CRW+1)'(MAX_OUTSTANDING)) w_cnext[p] = (CRW+1)'(MAX_OUTSTANDING);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++)
      r_credit[p] <= rst ? CRW'(MAX_OUTSTANDING) : w_cnext[p][CRW-1:0];
  end

  always_comb begin
    w_dq_in = '0;
    w_st_in = '0;
    w_fn_in = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_dq_in[p*DQW +: DQW] = {s_axis_status_dequeue_empty[p], s_axis_status_dequeue_error[p],
                               s_axis_status_dequeue_tag[p*TW +: TW]};
      w_st_in[p*STW +: STW] = {s_axis_status_start_error[p], s_axis_status_start_len[p*LEN_WIDTH +: LEN_WIDTH],
                               s_axis_status_start_tag[p*TW +: TW]};
      w_fn_in[p*FNW +: FNW] = {s_axis_status_finish_len[p*LEN_WIDTH +: LEN_WIDTH],
                               s_axis_status_finish_tag[p*TW +: TW]};
    end
    w_dq_in[PORTS*DQW +: DQW] = {1'b0, 1'b1, s_axis_req_tag};
  end

  tx_req_demux_merge #(.N(PORTS + 1), .W(DQW), .DEPTH(MAX_OUTSTANDING)) u_dq_merge (
    .clk(clk), .rst(rst), .i_valid({w_loc_push, s_axis_status_dequeue_valid}), .i_data(w_dq_in),
    .o_pop(w_dq_pop), .o_pop_data(w_dq_pop_data), .o_valid(m_axis_status_dequeue_valid), .o_data(w_dq_out)
  );
  tx_req_demux_merge #(.N(PORTS), .W(STW), .DEPTH(MAX_OUTSTANDING)) u_st_merge (
    .clk(clk), .rst(rst), .i_valid(s_axis_status_start_valid), .i_data(w_st_in),
    .o_pop(w_st_pop), .o_pop_data(w_st_pop_data), .o_valid(m_axis_status_start_valid), .o_data(w_st_out)
  );
  tx_req_demux_merge #(.N(PORTS), .W(FNW), .DEPTH(MAX_OUTSTANDING)) u_fn_merge (
    .clk(clk), .rst(rst), .i_valid(s_axis_status_finish_valid), .i_data(w_fn_in),
    .o_pop(w_fn_pop), .o_pop_data(w_fn_pop_data), .o_valid(m_axis_status_finish_valid), .o_data(w_fn_out)
  );

  assign w_unused_pop = ^{w_st_pop, w_st_pop_data, w_fn_pop_data};

  assign m_axis_status_dequeue_empty = w_dq_out[DQW-1];
  assign m_axis_status_dequeue_error = w_dq_out[DQW-2];
  assign m_axis_status_dequeue_tag   = w_dq_out[TW-1:0];
  assign m_axis_status_start_error   = w_st_out[STW-1];
  assign m_axis_status_start_len     = w_st_out[STW-2 -: LEN_WIDTH];
  assign m_axis_status_start_tag     = w_st_out[TW-1:0];
  assign m_axis_status_finish_len    = w_fn_out[FNW-1 -: LEN_WIDTH];
  assign m_axis_status_finish_tag    = w_fn_out[TW-1:0];
endmodule

// File: tb/tb_tx_req_demux.sv
// tb/tb_tx_req_demux.sv - scoreboard bench for tx_req_demux with three engines
module tb_tx_req_demux;
  localparam int P = 3, QI = 4, TW = 8, DW = 8, LW = 20, MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [QI-1:0]   s_axis_req_queue = '0;
  logic [TW-1:0]   s_axis_req_tag = '0;
  logic [DW-1:0]   s_axis_req_dest = '0;
  logic            s_axis_req_valid = 1'b0;
  logic            s_axis_req_ready;
  logic [P*QI-1:0] m_axis_req_queue;
  logic [P*TW-1:0] m_axis_req_tag;
  logic [P*DW-1:0] m_axis_req_dest;
  logic [P-1:0]    m_axis_req_valid;
  logic [P-1:0]    m_axis_req_ready = '1;
  logic [P-1:0]    s_dq_empty = '0, s_dq_error = '0, s_dq_valid = '0;
  logic [P*TW-1:0] s_dq_tag = '0;
  logic [P-1:0]    s_st_error = '0, s_st_valid = '0;
  logic [P*LW-1:0] s_st_len = '0;
  logic [P*TW-1:0] s_st_tag = '0;
  logic [P*LW-1:0] s_fn_len = '0;
  logic [P*TW-1:0] s_fn_tag = '0;
  logic [P-1:0]    s_fn_valid = '0;
  logic            m_dq_empty, m_dq_error, m_dq_valid;
  logic [TW-1:0]   m_dq_tag;
  logic            m_st_error, m_st_valid;
  logic [LW-1:0]   m_st_len;
  logic [TW-1:0]   m_st_tag;
  logic [LW-1:0]   m_fn_len;
  logic [TW-1:0]   m_fn_tag;
  logic            m_fn_valid;

  tx_req_demux #(.PORTS(P), .QUEUE_INDEX_WIDTH(QI), .REQ_TAG_WIDTH(TW), .DEST_WIDTH(DW),
                 .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_req_queue(s_axis_req_queue), .s_axis_req_tag(s_axis_req_tag),
    .s_axis_req_dest(s_axis_req_dest), .s_axis_req_valid(s_axis_req_valid),
    .s_axis_req_ready(s_axis_req_ready),
    .m_axis_req_queue(m_axis_req_queue), .m_axis_req_tag(m_axis_req_tag),
    .m_axis_req_dest(m_axis_req_dest), .m_axis_req_valid(m_axis_req_valid),
    .m_axis_req_ready(m_axis_req_ready),
    .s_axis_status_dequeue_empty(s_dq_empty), .s_axis_status_dequeue_error(s_dq_error),
    .s_axis_status_dequeue_tag(s_dq_tag), .s_axis_status_dequeue_valid(s_dq_valid),
    .s_axis_status_start_error(s_st_error), .s_axis_status_start_len(s_st_len),
    .s_axis_status_start_tag(s_st_tag), .s_axis_status_start_valid(s_st_valid),
    .s_axis_status_finish_len(s_fn_len), .s_axis_status_finish_tag(s_fn_tag),
    .s_axis_status_finish_valid(s_fn_valid),
    .m_axis_status_dequeue_empty(m_dq_empty), .m_axis_status_dequeue_error(m_dq_error),
    .m_axis_status_dequeue_tag(m_dq_tag), .m_axis_status_dequeue_valid(m_dq_valid),
    .m_axis_status_start_error(m_st_error), .m_axis_status_start_len(m_st_len),
    .m_axis_status_start_tag(m_st_tag), .m_axis_status_start_valid(m_st_valid),
    .m_axis_status_finish_len(m_fn_len), .m_axis_status_finish_tag(m_fn_tag),
    .m_axis_status_finish_valid(m_fn_valid)
  );

  typedef struct {
    int            port;
    logic          a;
    logic          b;
    logic [TW-1:0] tag;
    logic [LW-1:0] len;
    logic [QI-1:0] q;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_req[$], exp_dq[$], exp_st[$], exp_fn[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int port, input logic a, input logic b, input logic [TW-1:0] tag,
                              input logic [LW-1:0] len, input logic [QI-1:0] q, input logic [DW-1:0] d);
    ent_t e;
    e.port = port; e.a = a; e.b = b; e.tag = tag; e.len = len; e.q = q; e.d = d;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    ent_t e;
    if (!rst) begin
      for (int p = 0; p < P; p++) begin
        if (m_axis_req_valid[p] && m_axis_req_ready[p]) begin
          if (exp_req.size() == 0) check("req_unexpected", 1, 0);
          else begin
            e = exp_req.pop_front();
            check("req_port", p, e.port);
            check("req_tag", m_axis_req_tag[p*TW +: TW], e.tag);
            check("req_queue", m_axis_req_queue[p*QI +: QI], e.q);
            check("req_dest", m_axis_req_dest[p*DW +: DW], e.d);
          end
        end
      end
      if (m_dq_valid) begin
        if (exp_dq.size() == 0) check("dq_unexpected", 1, 0);
        else begin
          e = exp_dq.pop_front();
          check("dq_tag", m_dq_tag, e.tag);
          check("dq_empty", m_dq_empty, e.a);
          check("dq_error", m_dq_error, e.b);
        end
      end
      if (m_st_valid) begin
        if (exp_st.size() == 0) check("st_unexpected", 1, 0);
        else begin
          e = exp_st.pop_front();
          check("st_tag", m_st_tag, e.tag);
          check("st_error", m_st_error, e.a);
          check("st_len", m_st_len, e.len);
        end
      end
      if (m_fn_valid) begin
        if (exp_fn.size() == 0) check("fn_unexpected", 1, 0);
        else begin
          e = exp_fn.pop_front();
          check("fn_tag", m_fn_tag, e.tag);
          check("fn_len", m_fn_len, e.len);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_clear();
    tick();
    s_dq_valid = '0;
    s_st_valid = '0;
    s_fn_valid = '0;
  endtask

  task automatic set_dq(input int p, input logic emp, input logic err, input logic [TW-1:0] tag);
    s_dq_valid[p] = 1'b1; s_dq_empty[p] = emp; s_dq_error[p] = err; s_dq_tag[p*TW +: TW] = tag;
    exp_dq.push_back(mk(p, emp, err, tag, '0, '0, '0));
  endtask

  task automatic set_st(input int p, input logic err, input logic [LW-1:0] len, input logic [TW-1:0] tag);
    s_st_valid[p] = 1'b1; s_st_error[p] = err; s_st_len[p*LW +: LW] = len; s_st_tag[p*TW +: TW] = tag;
    exp_st.push_back(mk(p, err, 1'b0, tag, len, '0, '0));
  endtask

  task automatic set_fn(input int p, input logic [LW-1:0] len, input logic [TW-1:0] tag);
    s_fn_valid[p] = 1'b1; s_fn_len[p*LW +: LW] = len; s_fn_tag[p*TW +: TW] = tag;
    exp_fn.push_back(mk(p, 1'b0, 1'b0, tag, len, '0, '0));
  endtask

  task automatic send_req(input logic [DW-1:0] dest, input logic [TW-1:0] tag, input logic [QI-1:0] q);
    bit acc;
    bit ok;
    ok = 1'b0;
    s_axis_req_valid = 1'b1; s_axis_req_dest = dest; s_axis_req_tag = tag; s_axis_req_queue = q;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      acc = s_axis_req_ready;
      tick();
      if (acc) ok = 1'b1;
    end
    s_axis_req_valid = 1'b0;
    check("req_accept", ok, 1);
    if (ok) begin
      if (int'(dest[1:0]) >= P) exp_dq.push_back(mk(P, 1'b0, 1'b1, tag, '0, '0, '0));
      else exp_req.push_back(mk(int'(dest[1:0]), 1'b0, 1'b0, tag, '0, q, dest));
    end
  endtask

  task automatic stall_check(input string tag, input logic [DW-1:0] dest, input logic [TW-1:0] t);
    bit seen;
    seen = 1'b0;
    s_axis_req_valid = 1'b1; s_axis_req_dest = dest; s_axis_req_tag = t;
    repeat (4) begin
      @(negedge clk);
      seen |= s_axis_req_ready;
      tick();
    end
    s_axis_req_valid = 1'b0;
    check(tag, seen, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_axis_req_valid = 1'b0;
    tick();
    exp_req.delete(); exp_dq.delete(); exp_st.delete(); exp_fn.delete();
    check("rst_req_valid", m_axis_req_valid, 0);
    check("rst_status_valid", {m_dq_valid, m_st_valid, m_fn_valid}, 0);
    check("rst_req_ready", s_axis_req_ready, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit seen;
    int k;
    tick();
    tick();
    check("init_req_valid", m_axis_req_valid, 0);
    check("init_status_valid", {m_dq_valid, m_st_valid, m_fn_valid}, 0);
    check("init_ready_in_rst", s_axis_req_ready, 0);
    rst = 1'b0;
    #1;
    check("init_ready_after_rst", s_axis_req_ready, 1);

    // Single request to port 1, then its full status sequence.
    send_req(8'h01, 8'h5A, 4'h3);
    check("t1_valid_onehot", m_axis_req_valid, 3'b010);
    set_dq(1, 1'b0, 1'b0, 8'h5A); tick_clear();
    set_st(1, 1'b0, 20'h00100, 8'h5A); tick_clear();
    set_fn(1, 20'h00100, 8'h5A); tick_clear();
    repeat (4) tick();

    // Credit exhaustion on port 0 and recovery via a finish.
    for (int i = 0; i < MO; i++) send_req(8'h00, TW'(i), QI'(i));
    stall_check("t2_stall", 8'h00, 8'h04);
    s_axis_req_valid = 1'b1; s_axis_req_dest = 8'h00; s_axis_req_tag = 8'h04; s_axis_req_queue = 4'h4;
    set_fn(0, 20'h00010, 8'h00);
    acc = 1'b0; k = 0;
    while (!acc && k < 8) begin
      @(negedge clk);
      acc = s_axis_req_ready;
      tick();
      k++;
      s_fn_valid = '0;
    end
    s_axis_req_valid = 1'b0;
    check("t2_resume", (acc && k <= 3), 1);
    if (acc) exp_req.push_back(mk(0, 1'b0, 1'b0, 8'h04, '0, 4'h4, 8'h00));
    repeat (3) tick();

    // Empty dequeue returns exactly one credit.
    set_dq(0, 1'b1, 1'b0, 8'h01); tick_clear();
    send_req(8'h00, 8'h05, 4'h5);
    stall_check("t5_single_credit", 8'h00, 8'h06);
    repeat (3) tick();

    // Bad destination: local error status, one-deep slot.
    s_axis_req_valid = 1'b1; s_axis_req_dest = 8'h03; s_axis_req_tag = 8'h07;
    @(negedge clk);
    acc = s_axis_req_ready;
    check("t4_ready", acc, 1);
    tick();
    if (acc) exp_dq.push_back(mk(P, 1'b0, 1'b1, 8'h07, '0, '0, '0));
    check("t4_no_engine", m_axis_req_valid, 0);
    check("t4_dq_early", m_dq_valid, 0);
    s_axis_req_tag = 8'h08;
    @(negedge clk);
    check("t4_slot_stall", s_axis_req_ready, 0);
    tick();
    check("t4_dq_latency", m_dq_valid, 1);
    @(negedge clk);
    acc = s_axis_req_ready;
    check("t4_slot_free", acc, 1);
    tick();
    s_axis_req_valid = 1'b0;
    if (acc) exp_dq.push_back(mk(P, 1'b0, 1'b1, 8'h08, '0, '0, '0));
    check("t4_no_engine2", m_axis_req_valid, 0);
    repeat (4) tick();

    // Simultaneous finish on ports 0 and 1 from a fresh arbiter.
    apply_reset();
    send_req(8'h00, 8'h11, 4'h1);
    send_req(8'h01, 8'h22, 4'h2);
    repeat (2) tick();
    set_fn(0, 20'h00111, 8'h11);
    set_fn(1, 20'h00222, 8'h22);
    tick_clear();
    check("t3_n1_valid", m_fn_valid, 0);
    tick();
    check("t3_n2_valid", m_fn_valid, 1);
    check("t3_n2_tag", m_fn_tag, 8'h11);
    tick();
    check("t3_n3_valid", m_fn_valid, 1);
    check("t3_n3_tag", m_fn_tag, 8'h22);
    tick();
    check("t3_n4_valid", m_fn_valid, 0);
    repeat (2) tick();

    // Reset with a held request and buffered status.
    m_axis_req_ready = 3'b101;
    send_req(8'h01, 8'h61, 4'h1);
    check("t6_held", m_axis_req_valid, 3'b010);
    set_fn(0, 20'h00001, 8'h62);
    set_fn(2, 20'h00002, 8'h63);
    tick_clear();
    apply_reset();
    m_axis_req_ready = '1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= (m_axis_req_valid != '0) || m_dq_valid || m_st_valid || m_fn_valid;
      tick();
    end
    check("t6_discarded", seen, 0);
    for (int i = 0; i < MO; i++) send_req(8'h01, TW'(8'h70 + i), 4'h7);
    stall_check("t6_credit_full", 8'h01, 8'h7F);

    repeat (6) tick();
    check("drain_req", exp_req.size(), 0);
    check("drain_dq", exp_dq.size(), 0);
    check("drain_st", exp_st.size(), 0);
    check("drain_fn", exp_fn.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
